// File: rtl/pipe_skid_stage_pkg.sv
// Shared pipeline-stage definitions: state encoding,
// IF/ID field layout and the IF/ID bubble payload.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam int IFID_HALT_LSB  = 0;
  localparam int IFID_RS_LSB    = 1;
  localparam int IFID_INSTR_LSB = 17;
  localparam int IFID_PCOUT_LSB = 33;
  localparam int IFID_PCINC_LSB = 49;
  localparam int IFID_W         = 65;

  localparam logic [15:0] NOP_INSTR = 16'h4000;

  localparam logic [IFID_W-1:0] IFID_BUBBLE =
    {{(IFID_W-16){1'b0}}, NOP_INSTR} << IFID_INSTR_LSB;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake,
// one-entry skid buffer, flush and registered ready.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                   PAYLOAD_W  = IFID_W,
  parameter logic [PAYLOAD_W-1:0] BUBBLE_VAL = IFID_BUBBLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
);

  state_t                 r_state;
  logic [PAYLOAD_W-1:0]   r_main;
  logic [PAYLOAD_W-1:0]   r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_legal;

  // Handshake outputs come from state only, never from out_ready
  assign w_legal   = (r_state != ST_BAD);
  assign in_ready  = !rst && (r_state != ST_SKID);
  assign out_valid = (r_state == ST_FULL) ||
                     (r_state == ST_SKID);
  assign out_data  = r_main;
  assign occupancy = w_legal ? r_state : 2'd0;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // State, main and skid registers: reset > flush > handshake
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state <= ST_FULL;
            r_main  <= in_data;
          end
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_state <= ST_SKID;
            r_skid  <= in_data;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE_VAL;
          end
        end
        ST_SKID: begin
          if (w_out_fire) begin
            r_state <= ST_FULL;
            r_main  <= r_skid;
            r_skid  <= BUBBLE_VAL;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_main  <= BUBBLE_VAL;
          r_skid  <= BUBBLE_VAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table
// followed by a randomised run against a FIFO model.
module tb_pipe_skid_stage;

  localparam int W = 65;
  localparam logic [W-1:0] BUB =
    65'h0_0000_0000_8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_skid_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  typedef struct {
    logic         rst;
    logic         flush;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ov;
    logic [W-1:0] od;
    logic         ir;
    logic [1:0]   occ;
  } vec_t;

  function automatic vec_t mk(
    input logic rs, input logic fl,
    input logic iv, input logic [W-1:0] d,
    input logic ordy, input logic ov,
    input logic [W-1:0] od, input logic ir,
    input logic [1:0] occ);
    vec_t v;
    v.rst = rs; v.flush = fl; v.iv = iv;
    v.d = d; v.ordy = ordy; v.ov = ov;
    v.od = od; v.ir = ir; v.occ = occ;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  vec_t tv[31];

  // FIFO model for the random run
  logic [W-1:0] q[$];

  initial begin
    // rst flush iv data ordy | ov od ir occ
    tv[0]  = mk(1,0,1,1,0,    0,BUB,0,0);
    tv[1]  = mk(1,0,1,1,0,    0,BUB,0,0);
    tv[2]  = mk(0,0,0,0,1,    0,BUB,1,0);
    tv[3]  = mk(0,0,1,'h11,1, 0,BUB,1,0);
    tv[4]  = mk(0,0,1,'h12,1, 1,'h11,1,1);
    tv[5]  = mk(0,0,1,'h13,1, 1,'h12,1,1);
    tv[6]  = mk(0,0,0,0,1,    1,'h13,1,1);
    tv[7]  = mk(0,0,0,0,0,    0,BUB,1,0);
    tv[8]  = mk(0,0,1,'hA,0,  0,BUB,1,0);
    tv[9]  = mk(0,0,1,'hB,0,  1,'hA,1,1);
    tv[10] = mk(0,0,1,'hC,0,  1,'hA,0,2);
    tv[11] = mk(0,0,0,0,1,    1,'hA,0,2);
    tv[12] = mk(0,0,0,0,1,    1,'hB,1,1);
    tv[13] = mk(0,0,0,0,0,    0,BUB,1,0);
    tv[14] = mk(0,0,1,'hA,0,  0,BUB,1,0);
    tv[15] = mk(0,0,1,'hB,0,  1,'hA,1,1);
    tv[16] = mk(0,1,1,'hC,0,  1,'hA,0,2);
    tv[17] = mk(0,0,0,0,0,    0,BUB,1,0);
    tv[18] = mk(0,0,1,'hA,0,  0,BUB,1,0);
    tv[19] = mk(0,1,0,0,1,    1,'hA,1,1);
    tv[20] = mk(0,0,0,0,1,    0,BUB,1,0);
    tv[21] = mk(0,0,1,'hD,1,  0,BUB,1,0);
    tv[22] = mk(0,1,1,'hE,1,  1,'hD,1,1);
    tv[23] = mk(0,0,0,0,1,    0,BUB,1,0);
    tv[24] = mk(0,0,1,'h5,0,  0,BUB,1,0);
    tv[25] = mk(0,0,1,'h6,0,  1,'h5,1,1);
    tv[26] = mk(1,0,1,'h7,0,  1,'h5,0,2);
    tv[27] = mk(0,0,0,0,0,    0,BUB,1,0);
    tv[28] = mk(0,0,1,BUB,1,  0,BUB,1,0);
    tv[29] = mk(0,0,0,0,1,    1,BUB,1,1);
    tv[30] = mk(0,0,0,0,0,    0,BUB,1,0);

    rst = 1; flush = 0; in_valid = 1;
    in_data = 1; out_ready = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 31; i++) begin
      rst       = tv[i].rst;
      flush     = tv[i].flush;
      in_valid  = tv[i].iv;
      in_data   = tv[i].d;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d.out_valid", i),
          W'(out_valid), W'(tv[i].ov));
      chk($sformatf("v%0d.out_data", i),
          out_data, tv[i].od);
      chk($sformatf("v%0d.in_ready", i),
          W'(in_ready), W'(tv[i].ir));
      chk($sformatf("v%0d.occupancy", i),
          W'(occupancy), W'(tv[i].occ));
      @(posedge clk); #1;
    end

    // Random valid/ready/flush; stage is empty here
    rst = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic         fi, fo;
      logic [W-1:0] eod;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 31) == 0)
        in_data = BUB;
      else
        in_data = {$urandom, $urandom, $urandom};
      #1;
      eod = (q.size() > 0) ? q[0] : BUB;
      chk("rnd.occupancy", W'(occupancy),
          W'(q.size()));
      chk("rnd.out_valid", W'(out_valid),
          W'(q.size() > 0));
      chk("rnd.in_ready", W'(in_ready),
          W'(q.size() < 2));
      chk("rnd.out_data", out_data, eod);
      fi = in_valid && (q.size() < 2);
      fo = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (fo) void'(q.pop_front());
        if (fi) q.push_back(in_data);
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
